// File: rtl/fmc_mbox_regs.sv
// fmc_mbox_regs
//   BRAM-port register/mailbox slave sitting downstream of the FMC PSRAM
//   slave interface. Fixed 2-cycle read latency on bram_dout.
//   Provides ID, SCRATCH, CTRL, STATUS, and two 16-bit mailbox FIFOs:
//   TX (host -> fabric, AXI-Stream master) and RX (fabric -> host,
//   AXI-Stream slave), plus a registered level interrupt.
// Ports:
//   bram_clk, bram_rst_n        : clock, async active-low reset
//   bram_addr/en/we/din, dout   : BRAM-style host port (word addressed)
//   m_axis_tdata/tvalid/tready  : TX FIFO head towards fabric
//   s_axis_tdata/tvalid/tready  : RX FIFO input from fabric
//   irq                         : level interrupt to host
module fmc_mbox_regs #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 16,
  parameter int unsigned C_FIFO_DEPTH = 16,
  parameter logic [15:0] C_ID         = 16'hF3C1
) (
  input  logic                    bram_clk,
  input  logic                    bram_rst_n,
  input  logic [C_ADDR_WIDTH-1:0] bram_addr,
  input  logic                    bram_en,
  input  logic [1:0]              bram_we,
  input  logic [15:0]             bram_din,
  output logic [15:0]             bram_dout,
  output logic [15:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [15:0]             s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    irq
);

  generate
    if (C_DATA_WIDTH != 16) begin : g_bad_data_width
      $error("fmc_mbox_regs: C_DATA_WIDTH must be 16");
    end
    if ((C_FIFO_DEPTH < 4) || (C_FIFO_DEPTH > 256) ||
        ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fmc_mbox_regs: C_FIFO_DEPTH must be a power of two in 4..256");
    end
    if (C_ADDR_WIDTH < 5) begin : g_bad_addr_width
      $error("fmc_mbox_regs: C_ADDR_WIDTH must be at least 5");
    end
  endgenerate

  localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(C_FIFO_DEPTH);

  typedef enum logic [3:0] {
    REG_ID       = 4'h0,
    REG_SCRATCH  = 4'h1,
    REG_CTRL     = 4'h2,
    REG_STATUS   = 4'h3,
    REG_TX_DATA  = 4'h4,
    REG_RX_DATA  = 4'h5,
    REG_RX_LEVEL = 4'h6,
    REG_TX_LEVEL = 4'h7
  } reg_sel_e;

  // State
  logic [15:0]   scratch_q, scratch_d;
  logic          irq_en_q, irq_en_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_unf_q, rx_unf_d;
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          irq_q, irq_d;
  logic          rd_vld_q, rd_vld_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic [15:0]   dout_q, dout_d;

  logic [15:0]   tx_mem_q [C_FIFO_DEPTH];
  logic [15:0]   rx_mem_q [C_FIFO_DEPTH];

  // Decode
  logic     in_range, rd_en, wr_en;
  reg_sel_e reg_sel;
  logic     tx_full, tx_empty, rx_full, rx_empty;
  logic     tx_push, tx_pop, rx_push, rx_pop;
  logic     tx_mem_we, rx_mem_we;
  logic     flush;
  logic [15:0] rx_head, status, rd_mux;

  assign in_range = (bram_addr[C_ADDR_WIDTH-1:4] == '0);
  assign reg_sel  = reg_sel_e'(bram_addr[3:0]);
  assign rd_en    = bram_en && (bram_we == 2'b00);
  assign wr_en    = bram_en && (bram_we != 2'b00) && in_range;

  assign tx_full  = (tx_level_q == FULL_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == FULL_LVL);
  assign rx_empty = (rx_level_q == '0);

  assign rx_head = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign status  = {10'b0, rx_unf_q, tx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      case (reg_sel)
        REG_ID:       rd_mux = C_ID;
        REG_SCRATCH:  rd_mux = scratch_q;
        REG_CTRL:     rd_mux = {14'b0, irq_en_q, 1'b0};
        REG_STATUS:   rd_mux = status;
        REG_RX_DATA:  rd_mux = rx_head;
        REG_RX_LEVEL: rd_mux = 16'(rx_level_q);
        REG_TX_LEVEL: rd_mux = 16'(tx_level_q);
        default:      rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    logic wr_scratch, wr_ctrl, wr_status, tx_push_req, rx_pop_req;
    logic tx_ovf_set, rx_unf_set;

    scratch_d   = scratch_q;
    irq_en_d    = irq_en_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    rx_level_d  = rx_level_q;

    wr_scratch  = wr_en && (reg_sel == REG_SCRATCH);
    wr_ctrl     = wr_en && (reg_sel == REG_CTRL) && bram_we[0];
    wr_status   = wr_en && (reg_sel == REG_STATUS) && bram_we[0];
    tx_push_req = wr_en && (reg_sel == REG_TX_DATA);
    rx_pop_req  = wr_en && (reg_sel == REG_RX_DATA);

    if (wr_scratch && bram_we[1]) scratch_d[15:8] = bram_din[15:8];
    if (wr_scratch && bram_we[0]) scratch_d[7:0]  = bram_din[7:0];
    if (wr_ctrl) irq_en_d = bram_din[1];
    flush = wr_ctrl && bram_din[0];

    // A full TX FIFO still accepts a push when the stream pops it the same edge.
    tx_pop     = !tx_empty && m_axis_tready;
    tx_push    = tx_push_req && (!tx_full || tx_pop);
    tx_ovf_set = tx_push_req && tx_full && !tx_pop;

    // The pop test uses the pre-edge level, so a same-edge push into an empty
    // RX FIFO still lands and the pop counts as an underflow.
    rx_push    = s_axis_tvalid && rx_rdy_q;
    rx_pop     = rx_pop_req && !rx_empty;
    rx_unf_set = rx_pop_req && rx_empty;

    // Set wins over a same-edge W1C.
    tx_ovf_d = (tx_ovf_q && !(wr_status && bram_din[4])) || tx_ovf_set;
    rx_unf_d = (rx_unf_q && !(wr_status && bram_din[5])) || rx_unf_set;

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
    rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);

    if (flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      tx_level_d  = '0;
      rx_level_d  = '0;
      tx_ovf_d    = 1'b0;
      rx_unf_d    = 1'b0;
    end

    tx_mem_we = tx_push && !flush;
    rx_mem_we = rx_push && !flush;

    rx_rdy_d = (rx_level_d != FULL_LVL);
    irq_d    = irq_en_q && (!rx_empty || tx_ovf_q || rx_unf_q);

    rd_vld_d  = rd_en;
    rd_data_d = rd_en ? rd_mux : rd_data_q;
    dout_d    = rd_vld_q ? rd_data_q : dout_q;
  end

  always_ff @(posedge bram_clk or negedge bram_rst_n) begin
    if (!bram_rst_n) begin
      scratch_q   <= '0;
      irq_en_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_unf_q    <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      rx_rdy_q    <= 1'b0;
      irq_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      dout_q      <= '0;
    end else begin
      scratch_q   <= scratch_d;
      irq_en_q    <= irq_en_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_unf_q    <= rx_unf_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_level_q  <= rx_level_d;
      rx_rdy_q    <= rx_rdy_d;
      irq_q       <= irq_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
      dout_q      <= dout_d;
    end
  end

  // FIFO storage carries no reset; the outputs are gated by the levels.
  always_ff @(posedge bram_clk) begin
    if (tx_mem_we) tx_mem_q[tx_wr_ptr_q] <= bram_din;
    if (rx_mem_we) rx_mem_q[rx_wr_ptr_q] <= s_axis_tdata;
  end

  assign bram_dout     = dout_q;
  assign m_axis_tvalid = !tx_empty;
  assign m_axis_tdata  = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign s_axis_tready = rx_rdy_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_fmc_mbox_regs.sv
module tb_fmc_mbox_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bram_addr = '0;
  logic        bram_en = 1'b0;
  logic [1:0]  bram_we = '0;
  logic [15:0] bram_din = '0;
  logic [15:0] bram_dout;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  logic rd_s1, rd_s2;

  fmc_mbox_regs #(
    .C_ADDR_WIDTH(12),
    .C_DATA_WIDTH(16),
    .C_FIFO_DEPTH(16),
    .C_ID(16'hF3C1)
  ) dut (
    .bram_clk(clk),
    .bram_rst_n(rst_n),
    .bram_addr(bram_addr),
    .bram_en(bram_en),
    .bram_we(bram_we),
    .bram_din(bram_din),
    .bram_dout(bram_dout),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Bench-side record of when each issued read should surface on bram_dout.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      rd_s1 <= bram_en && (bram_we == 2'b00);
      rd_s2 <= rd_s1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rd_s2) begin
      if (sb.size() == 0) begin
        $display("FAIL unexpected_read: got %h with no expected entry", bram_dout);
        n_fail++;
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (bram_dout !== e.exp) begin
          $display("FAIL %s: got %h expected %h", e.name, bram_dout, e.exp);
          n_fail++;
        end
      end
      n_checks++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [11:0] a, input logic [15:0] exp, input string name);
    bram_en   = 1'b1;
    bram_we   = 2'b00;
    bram_addr = a;
    sb.push_back('{exp, name});
    tick();
    bram_en   = 1'b0;
  endtask

  task automatic host_write(input logic [11:0] a, input logic [1:0] we, input logic [15:0] d);
    bram_en   = 1'b1;
    bram_we   = we;
    bram_addr = a;
    bram_din  = d;
    tick();
    bram_en   = 1'b0;
    bram_we   = 2'b00;
    bram_din  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d reads outstanding, expected 0", sb.size());
      n_fail++;
      sb.delete();
    end
    n_checks++;
  endtask

  task automatic test_reset();
    logic [15:0] exp_seq [8];
    exp_seq = '{16'hF3C1, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    repeat (3) tick();
    if ({bram_dout, m_axis_tdata, m_axis_tvalid, s_axis_tready, irq} !== 35'd0) begin
      $display("FAIL reset_outputs: got dout=%h tdata=%h tvalid=%b tready=%b irq=%b expected all 0",
               bram_dout, m_axis_tdata, m_axis_tvalid, s_axis_tready, irq);
      n_fail++;
    end
    n_checks++;
    rst_n = 1'b1;
    if (s_axis_tready !== 1'b0) begin
      $display("FAIL tready_before_edge: got %b expected 0", s_axis_tready);
      n_fail++;
    end
    n_checks++;
    tick();
    if (s_axis_tready !== 1'b1) begin
      $display("FAIL tready_first_edge: got %b expected 1", s_axis_tready);
      n_fail++;
    end
    n_checks++;
    for (int unsigned a = 0; a < 8; a++) host_read(12'(a), exp_seq[a], $sformatf("reset_read_%0d", a));
    drain();
  endtask

  task automatic test_scratch();
    host_write(12'h001, 2'b11, 16'hABCD);
    host_read(12'h001, 16'hABCD, "scratch_full");
    host_write(12'h001, 2'b01, 16'h1234);
    host_read(12'h001, 16'hAB34, "scratch_byte0");
    host_read(12'h010, 16'h0000, "out_of_range_read");
    host_write(12'h011, 2'b11, 16'hFFFF);
    host_read(12'h001, 16'hAB34, "scratch_after_oor_write");
    host_read(12'h00F, 16'h0000, "unmapped_read");
    drain();
  endtask

  task automatic test_tx_overflow();
    logic [15:0] txq[$];
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 17; i++) begin
      host_write(12'h004, 2'b11, 16'(i));
      if (i < 16) txq.push_back(16'(i));
    end
    host_read(12'h007, 16'd16, "tx_level_full");
    host_read(12'h003, 16'h0019, "status_tx_full_ovf");
    drain();
    for (int unsigned i = 0; i < 16; i++) begin
      logic [15:0] e;
      m_axis_tready = 1'b1;
      e = txq.pop_front();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e) begin
        $display("FAIL tx_stream_%0d: got v=%b d=%h expected v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, e);
        n_fail++;
      end
      n_checks++;
      tick();
    end
    m_axis_tready = 1'b0;
    if (m_axis_tvalid !== 1'b0) begin
      $display("FAIL tx_drained_tvalid: got %b expected 0", m_axis_tvalid);
      n_fail++;
    end
    n_checks++;
    host_read(12'h003, 16'h0015, "status_tx_empty_ovf");
    host_write(12'h003, 2'b01, 16'h0010);
    host_read(12'h003, 16'h0005, "status_ovf_cleared");
    drain();
    host_write(12'h004, 2'b11, 16'hBEEF);
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hBEEF) begin
      $display("FAIL tx_first_word: got v=%b d=%h expected v=1 d=beef", m_axis_tvalid, m_axis_tdata);
      n_fail++;
    end
    n_checks++;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    if (m_axis_tvalid !== 1'b0) begin
      $display("FAIL tx_single_pop: got %b expected 0", m_axis_tvalid);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_rx_irq();
    logic [15:0] words [3];
    words = '{16'h0011, 16'h0022, 16'h0033};
    host_write(12'h002, 2'b01, 16'h0002);
    if (irq !== 1'b0) begin
      $display("FAIL irq_idle: got %b expected 0", irq);
      n_fail++;
    end
    n_checks++;
    for (int unsigned i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[i];
      tick();
      if (i == 1) begin
        if (irq !== 1'b1) begin
          $display("FAIL irq_after_push: got %b expected 1", irq);
          n_fail++;
        end
        n_checks++;
      end
    end
    s_axis_tvalid = 1'b0;
    host_read(12'h005, 16'h0011, "rx_peek_1");
    host_read(12'h005, 16'h0011, "rx_peek_2");
    host_write(12'h005, 2'b11, 16'h0000);
    host_read(12'h005, 16'h0022, "rx_after_pop");
    repeat (3) host_write(12'h005, 2'b11, 16'h0000);
    host_read(12'h006, 16'h0000, "rx_level_empty");
    host_read(12'h003, 16'h0025, "status_underflow");
    host_read(12'h005, 16'h0000, "rx_empty_read");
    drain();
    if (irq !== 1'b1) begin
      $display("FAIL irq_underflow_held: got %b expected 1", irq);
      n_fail++;
    end
    n_checks++;
    host_write(12'h003, 2'b01, 16'h0020);
    tick();
    if (irq !== 1'b0) begin
      $display("FAIL irq_after_w1c: got %b expected 0", irq);
      n_fail++;
    end
    n_checks++;
    host_read(12'h003, 16'h0005, "status_unf_cleared");
    drain();
  endtask

  task automatic test_rx_full();
    logic [15:0] rxq[$];
    for (int unsigned i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 16'(16'h00A0 + i);
      if (s_axis_tready !== 1'b1) begin
        $display("FAIL rx_fill_ready_%0d: got %b expected 1", i, s_axis_tready);
        n_fail++;
      end
      n_checks++;
      rxq.push_back(s_axis_tdata);
      tick();
    end
    s_axis_tdata = 16'h00EE;
    if (s_axis_tready !== 1'b0) begin
      $display("FAIL rx_full_ready: got %b expected 0", s_axis_tready);
      n_fail++;
    end
    n_checks++;
    tick();
    host_read(12'h006, 16'd16, "rx_level_full");
    host_read(12'h003, 16'h0006, "status_rx_full");
    host_write(12'h005, 2'b11, 16'h0000);
    void'(rxq.pop_front());
    if (s_axis_tready !== 1'b1) begin
      $display("FAIL rx_ready_after_pop: got %b expected 1", s_axis_tready);
      n_fail++;
    end
    n_checks++;
    rxq.push_back(16'h00EE);
    tick();
    s_axis_tvalid = 1'b0;
    host_read(12'h006, 16'd16, "rx_level_refilled");
    for (int unsigned i = 0; i < 16; i++) begin
      host_read(12'h005, rxq[i], $sformatf("rx_order_%0d", i));
      host_write(12'h005, 2'b11, 16'h0000);
    end
    host_read(12'h006, 16'h0000, "rx_level_drained");
    drain();
  endtask

  task automatic test_flush();
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 17; i++) host_write(12'h004, 2'b11, 16'(16'h0100 + i));
    for (int unsigned i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 16'(16'h0200 + i);
      tick();
    end
    s_axis_tdata = 16'h0055;
    host_write(12'h002, 2'b01, 16'h0003);
    s_axis_tvalid = 1'b0;
    if (m_axis_tvalid !== 1'b0) begin
      $display("FAIL flush_tvalid: got %b expected 0", m_axis_tvalid);
      n_fail++;
    end
    n_checks++;
    host_read(12'h003, 16'h0005, "flush_status");
    host_read(12'h006, 16'h0000, "flush_rx_level");
    host_read(12'h007, 16'h0000, "flush_tx_level");
    host_read(12'h002, 16'h0002, "flush_ctrl_readback");
    host_read(12'h001, 16'hAB34, "flush_scratch_kept");
    host_read(12'h005, 16'h0000, "flush_rx_data");
    drain();
  endtask

  task automatic test_back_to_back_reset();
    for (int unsigned i = 0; i < 3; i++) host_write(12'h004, 2'b11, 16'(16'h0300 + i));
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h0404;
    tick();
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    if (irq !== 1'b1) begin
      $display("FAIL irq_before_reset: got %b expected 1", irq);
      n_fail++;
    end
    n_checks++;
    host_read(12'h000, 16'hF3C1, "burst_id_0");
    host_read(12'h000, 16'hF3C1, "burst_id_1");
    bram_en   = 1'b1;
    bram_addr = 12'h000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if ({bram_dout, m_axis_tdata, m_axis_tvalid, s_axis_tready, irq} !== 35'd0) begin
      $display("FAIL async_reset_outputs: got dout=%h tdata=%h tvalid=%b tready=%b irq=%b expected all 0",
               bram_dout, m_axis_tdata, m_axis_tvalid, s_axis_tready, irq);
      n_fail++;
    end
    n_checks++;
    bram_en = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    host_read(12'h007, 16'h0000, "post_reset_tx_level");
    host_read(12'h006, 16'h0000, "post_reset_rx_level");
    host_read(12'h001, 16'h0000, "post_reset_scratch");
    host_read(12'h002, 16'h0000, "post_reset_ctrl");
    host_read(12'h003, 16'h0005, "post_reset_status");
    drain();
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_tx_overflow();
    test_rx_irq();
    test_rx_full();
    test_flush();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
